volume_window_controller: RTL
=============================

// Module: volume_window_controller
// PURPOSE
//  Sequences the mic volume datapath: gathers 12-bit mic samples on a 20 kHz sample strobe.
//  Tracks the peak over fixed windows and hands each window's peak to a multi-cycle threshold evaluator.
//  Publishes a level (0..NUM_LEVELS) plus a thermometer LED bar for the LEDs and the OLED border renderer.
//  Sits between the audio capture block and the led/oled consumers, all in the CLK100MHZ domain.
// PARAMETERS
//  WINDOW        2000  samples per evaluation window (>= NUM_LEVELS+2)
//  THRESH_BASE   2048  lowest threshold (mic midscale = silence)
//  THRESH_STEP   450   spacing between thresholds; T[k] = THRESH_BASE + k*THRESH_STEP
//  NUM_LEVELS    5     number of thresholds/levels, 1..12
//  HOLD_WINDOWS  4     windows a held level persists before decaying one step (PEAK_HOLD_EN only)
// PORTS
//  CLK100MHZ     in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  enable        in   1   1 = run; 0 = accumulator idle, outputs frozen
//  sample_tick   in   1   one-cycle strobe, mic_in valid on this cycle
//  mic_in        in   12  unsigned mic sample
//  level         out  4   published level, 0..NUM_LEVELS
//  led           out  12  thermometer: led[i] = (level > i)
//  level_valid   out  1   one-cycle pulse when level/led/peak_out update
//  peak_out      out  12  raw peak of the most recent evaluated window
//  busy          out  1   evaluator running
// BEHAVIOUR
//  Reset: level=0, led=0, level_valid=0, peak_out=0, busy=0; accumulator peak=0, sample count=0, FSM=IDLE.
//  Accumulator (independent of evaluator):
//   - enable=0: peak and count held at 0, ticks ignored.
//   - on sample_tick: peak <= max(peak, mic_in); count++.
//   - tick with count==WINDOW-1: snapshot max(peak,mic_in) into eval_peak.
//     Then peak<=0, count<=0, start evaluator. No tick is ever lost across window boundaries.
//   - enable falling mid-window: window discarded (peak/count cleared).
//     A running evaluation still completes and publishes.
//  Evaluator FSM: IDLE -> CMP -> PUBLISH -> IDLE.
//   - IDLE: busy=0; on snapshot -> CMP, k=0, acc_level=0.
//   - CMP: one threshold per cycle; if eval_peak > T[k] (strict), acc_level=k+1.
//     Thresholds are compared in ascending order. k++; after k==NUM_LEVELS-1 -> PUBLISH. busy=1.
//   - PUBLISH: level, led and peak_out register; level_valid=1 for this cycle only; -> IDLE.
//   - Latency: snapshot tick to level_valid = NUM_LEVELS+1 cycles.
//   - Snapshot while busy cannot occur given the WINDOW constraint; if forced, the new snapshot restarts CMP.
//  Arithmetic: threshold sums in 13 bits. Thresholds >= 4095 are never exceeded.
//  Level saturates at NUM_LEVELS.
//  Reset mid-CMP: evaluation aborted, no level_valid pulse.
//  sample_tick together with reset: reset wins.
// CONFIGURATION
//  PEAK_HOLD_EN defined: published level is a held level H.
//   - On each PUBLISH with new level L: if L >= H then H<=L, hold_cnt<=0.
//   - Else hold_cnt++; when hold_cnt reaches HOLD_WINDOWS-1: H<=max(H-1,L), hold_cnt<=0.
//   - level/led reflect H; peak_out stays raw.
//   - Reset clears H and hold_cnt.
//  PEAK_HOLD_EN undefined: level = L directly each window; no hold registers.
// TESTING
//  1 Reset, enable=1, 2000 ticks of mic_in=2048 -> level_valid after tick 2000 + 6 cycles; level=0, led=0.
//  2 Window with a single 2049, rest 2000 -> level=1, led=12'h001, peak_out=2049.
//    Same window with 2498 -> level=1; with 2499 -> level=2.
//  3 Window containing 4095 -> level=5, led=12'h01F.
//    Back-to-back windows: tick one cycle after the snapshot is counted in the next window.
//  4 enable dropped at tick 1000, raised again later -> no level_valid for that window.
//    Next full 2000-tick window publishes normally.
//  5 PEAK_HOLD_EN: window L=5 then windows L=0 -> level stays 5 for 3 windows, then 4,4,4,4,3...
//    Undefined: second window gives level=0.
//  6 reset asserted during CMP -> no level_valid, all outputs 0 next cycle.

Source files
------------

// File: rtl/volume_window_controller_if.sv
// ---------------------------------------------------------------------------
// volume_window_controller_if
// Bundles the sample input and level output signals of the mic volume
// window controller.
//   master : audio side / consumer side driver (drives enable, sample_tick,
//            mic_in; observes level, led, level_valid, peak_out, busy)
//   slave  : the controller itself
// Signals
//   enable       1 = run, 0 = accumulator idle
//   sample_tick  one-cycle strobe, mic_in valid on this cycle
//   mic_in       12-bit unsigned mic sample
//   level        published level, 0..NUM_LEVELS
//   led          thermometer bar, led[i] = (level > i)
//   level_valid  one-cycle pulse when level/led/peak_out update
//   peak_out     raw peak of the most recent evaluated window
//   busy         threshold evaluator running
// ---------------------------------------------------------------------------
interface volume_window_controller_if;
    logic        enable;
    logic        sample_tick;
    logic [11:0] mic_in;
    logic [3:0]  level;
    logic [11:0] led;
    logic        level_valid;
    logic [11:0] peak_out;
    logic        busy;

    modport master (
        output enable, sample_tick, mic_in,
        input  level, led, level_valid, peak_out, busy
    );

    modport slave (
        input  enable, sample_tick, mic_in,
        output level, led, level_valid, peak_out, busy
    );
endinterface

// File: rtl/volume_window_controller.sv
// ---------------------------------------------------------------------------
// volume_window_controller
// Gathers 12-bit mic samples on sample_tick, tracks the peak over windows of
// WINDOW samples and hands each window's peak to a threshold evaluator that
// compares one threshold per cycle (T[k] = THRESH_BASE + k*THRESH_STEP).
// The resulting level (0..NUM_LEVELS) is published with a thermometer LED
// bar, the raw window peak and a one-cycle level_valid pulse.
// Ports
//   CLK100MHZ  in  system clock
//   reset      in  synchronous, active-high reset
//   bus        slave modport of volume_window_controller_if
// Optional feature macro
//   PEAK_HOLD_EN : publish a held level that decays one step after
//                  HOLD_WINDOWS windows below it (peak_out stays raw).
// ---------------------------------------------------------------------------
module volume_window_controller #(
    parameter int WINDOW      = 2000,
    parameter int THRESH_BASE = 2048,
    parameter int THRESH_STEP = 450,
    parameter int NUM_LEVELS  = 5
`ifdef PEAK_HOLD_EN
    ,
    parameter int HOLD_WINDOWS = 4
`endif
) (
    input  logic                        CLK100MHZ,
    input  logic                        reset,
    volume_window_controller_if.slave   bus
);

    localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CMP     = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;

    // ------------------------------------------------------------------
    // Threshold table. Sums are held in 13 bits and saturate, so any
    // threshold at or above 4095 can never be exceeded by a 12-bit peak.
    // Unused slots are filled with the saturated value.
    // ------------------------------------------------------------------
    logic [12:0] thr_tab [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_thr
            if (gi < NUM_LEVELS) begin : g_used
                localparam int RAW = THRESH_BASE + gi * THRESH_STEP;
                localparam logic [12:0] T13 = (RAW > 8191) ? 13'h1FFF : 13'(RAW);
                assign thr_tab[gi] = T13;
            end else begin : g_unused
                assign thr_tab[gi] = 13'h1FFF;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Window accumulator
    // ------------------------------------------------------------------
    logic [11:0]   peak_q;
    logic [CW-1:0] count_q;
    logic [11:0]   eval_peak_q;
    logic [11:0]   tick_max;
    logic          snapshot;

    assign tick_max = (bus.mic_in > peak_q) ? bus.mic_in : peak_q;
    assign snapshot = bus.enable && bus.sample_tick && (count_q == CW'(WINDOW - 1));

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            peak_q      <= '0;
            count_q     <= '0;
            eval_peak_q <= '0;
        end else if (!bus.enable) begin
            // Dropping enable discards the partial window.
            peak_q  <= '0;
            count_q <= '0;
        end else if (bus.sample_tick) begin
            if (snapshot) begin
                // The closing sample itself is part of the snapshot.
                eval_peak_q <= tick_max;
                peak_q      <= '0;
                count_q     <= '0;
            end else begin
                peak_q  <= tick_max;
                count_q <= count_q + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Evaluator FSM: IDLE -> CMP (NUM_LEVELS cycles) -> PUBLISH -> IDLE
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic [3:0] k_q, k_d;
    logic [3:0] acc_q, acc_d;
    logic       publish;
    logic       exceed;

    assign exceed = ({1'b0, eval_peak_q} > thr_tab[k_q]);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        publish = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_CMP: begin
                // Ascending order: the last exceeded threshold wins.
                if (exceed) begin
                    acc_d = k_q + 4'd1;
                end
                if (k_q == 4'(NUM_LEVELS - 1)) begin
                    state_d = ST_PUBLISH;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            ST_PUBLISH: begin
                publish = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh snapshot always (re)starts the comparison sweep.
        if (snapshot) begin
            state_d = ST_CMP;
            k_d     = '0;
            acc_d   = '0;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Level selection (raw or held)
    // ------------------------------------------------------------------
    logic [3:0] pub_level;

`ifdef PEAK_HOLD_EN
    localparam int HCW = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;

    logic [3:0]     hold_q, hold_d;
    logic [HCW-1:0] hcnt_q, hcnt_d;

    always_comb begin
        hold_d = hold_q;
        hcnt_d = hcnt_q;
        if (publish) begin
            if (acc_q >= hold_q) begin
                hold_d = acc_q;
                hcnt_d = '0;
            end else if (hcnt_q == HCW'(HOLD_WINDOWS - 1)) begin
                // hold_q > acc_q here, so hold_q - 1 cannot underflow.
                hold_d = ((hold_q - 4'd1) > acc_q) ? (hold_q - 4'd1) : acc_q;
                hcnt_d = '0;
            end else begin
                hcnt_d = hcnt_q + HCW'(1);
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            hold_q <= '0;
            hcnt_q <= '0;
        end else begin
            hold_q <= hold_d;
            hcnt_q <= hcnt_d;
        end
    end

    assign pub_level = hold_d;
`else
    assign pub_level = acc_q;
`endif

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [11:0] led_d;

    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_led
            assign led_d[gi] = (pub_level > 4'(gi));
        end
    endgenerate

    logic [3:0]  level_q;
    logic [11:0] led_q;
    logic        valid_q;
    logic [11:0] peak_out_q;

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            level_q    <= '0;
            led_q      <= '0;
            valid_q    <= 1'b0;
            peak_out_q <= '0;
        end else begin
            valid_q <= publish;
            if (publish) begin
                level_q    <= pub_level;
                led_q      <= led_d;
                peak_out_q <= eval_peak_q;
            end
        end
    end

    assign bus.level       = level_q;
    assign bus.led         = led_q;
    assign bus.level_valid = valid_q;
    assign bus.peak_out    = peak_out_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule
